// File: rtl/mem_word_reader_if.sv
// rtl/mem_word_reader_if.sv - start/status, RAM read port and output stream bundle for mem_word_reader
//
// Signals (directions seen from the reader, i.e. the master modport):
//   start      in   request a transfer (honoured only while idle)
//   busy       out  transfer in progress
//   done       out  one-cycle completion pulse
//   mem_re     out  RAM read enable; data comes back on mem_data one cycle later
//   mem_addr   out  RAM word address, meaningful while mem_re=1
//   mem_data   in   RAM read data
//   out_valid  out  out_data/out_last hold a word
//   out_ready  in   consumer takes the word when out_valid & out_ready
//   out_data   out  word payload
//   out_last   out  marks the final word of a transfer
interface mem_word_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        input  start,
        input  mem_data,
        input  out_ready,
        output busy,
        output done,
        output mem_re,
        output mem_addr,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output start,
        output mem_data,
        output out_ready,
        input  busy,
        input  done,
        input  mem_re,
        input  mem_addr,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/mem_word_reader.sv
// rtl/mem_word_reader.sv - reads WORD_COUNT consecutive RAM words from BASE_ADDR and streams them out
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset; aborts any transfer, drops any read in flight
//   bus    mem_word_reader_if.master: start/busy/done, RAM read port
//          (mem_re/mem_addr/mem_data) and output stream (out_valid/out_ready/out_data/out_last)
module mem_word_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int BASE_ADDR  = 0,
    parameter int WORD_COUNT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_word_reader_if.master bus
);
    // One extra bit so the counter can index WORD_COUNT = 2**ADDR_W words.
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORD_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  issue_cnt;

    // Tracks the read issued last cycle: its data is on mem_data this cycle.
    logic              ret_valid;
    logic              ret_last;

    // Two-entry return buffer; each entry carries its last-word tag.
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              fifo_nonempty;
    logic              pop;
    logic              push;
    logic              issue;
    logic              issue_last;
    logic [2:0]        committed;

    always_comb begin
        fifo_nonempty = (fifo_cnt != 2'd0);
        pop           = fifo_nonempty && bus.out_ready;
        push          = ret_valid;
        // Words that will still occupy the buffer after this cycle, counting
        // the one arriving on mem_data. A new read lands one cycle after the
        // arriving one, so issuing is safe whenever this is below two, and
        // with a consumer that never stalls it stays at one.
        committed     = {1'b0, fifo_cnt} + {2'b00, ret_valid} - {2'b00, pop};
        issue         = (state == S_READ) && (committed < 3'd2);
        issue_last    = issue && (issue_cnt == LAST_IDX);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bus.start) state_next = S_READ;
            S_READ:   if (issue_last) state_next = S_DRAIN;
            S_DRAIN:  if (pop && fifo_last[rd_ptr]) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            issue_cnt    <= '0;
            ret_valid    <= 1'b0;
            ret_last     <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= 2'b00;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
        end else begin
            state     <= state_next;
            ret_valid <= issue;
            ret_last  <= issue_last;

            if (state == S_IDLE) begin
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
            end

            if (push) begin
                fifo_data[wr_ptr] <= bus.mem_data;
                fifo_last[wr_ptr] <= ret_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // The address is held steady through the whole READ phase (even while
    // throttled) and parked at zero otherwise, so the RAM side never toggles
    // outside READ.
    always_comb begin
        bus.busy      = (state == S_READ) || (state == S_DRAIN);
        bus.done      = (state == S_FINISH);
        bus.mem_re    = issue;
        bus.mem_addr  = (state == S_READ) ? (BASE + issue_cnt[ADDR_W-1:0]) : '0;
        bus.out_valid = fifo_nonempty;
        bus.out_data  = fifo_nonempty ? fifo_data[rd_ptr] : '0;
        bus.out_last  = fifo_nonempty && fifo_last[rd_ptr];
    end
endmodule

// File: tb/tb_mem_word_reader.sv
// tb/tb_mem_word_reader.sv - self-checking bench for mem_word_reader (three parameterisations side by side)
module tb_mem_word_reader;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b1;
    int   cyc   = 0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram [256];

    // u0: base 0, 8 words; u1: base FE, 4 words (wrap); u2: base 0, 1 word
    int base_a [3] = '{0, 254, 0};
    int wc_a   [3] = '{8, 4, 1};

    mem_word_reader_if #(.ADDR_W(8), .DATA_W(32)) ia ();
    mem_word_reader_if #(.ADDR_W(8), .DATA_W(32)) ib ();
    mem_word_reader_if #(.ADDR_W(8), .DATA_W(32)) ic ();

    assign ia.start = start;
    assign ib.start = start;
    assign ic.start = start;
    assign ia.out_ready = ready;
    assign ib.out_ready = ready;
    assign ic.out_ready = ready;

    mem_word_reader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(0), .WORD_COUNT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    mem_word_reader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(254), .WORD_COUNT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));
    mem_word_reader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(0), .WORD_COUNT(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ic));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with one-cycle read latency, one read port per reader
    always @(posedge clk) begin
        if (ia.mem_re) ia.mem_data <= ram[ia.mem_addr];
        if (ib.mem_re) ib.mem_data <= ram[ib.mem_addr];
        if (ic.mem_re) ic.mem_data <= ram[ic.mem_addr];
    end

    // Transfer-level model: expected busy/done, words issued and words taken
    int m_busy   [3] = '{0, 0, 0};
    int m_done   [3] = '{0, 0, 0};
    int m_issued [3] = '{0, 0, 0};
    int m_popped [3] = '{0, 0, 0};
    int m_hold   [3] = '{0, 0, 0};

    // Event records used by the hand-computed expectations
    int          rec_re          [3];
    int          rec_pop         [3];
    int          rec_done        [3];
    int          rec_done_cyc    [3];
    int          rec_first_valid [3];
    logic [31:0] rec_first_word  [3];
    logic [31:0] rec_last_word   [3];
    logic        rec_last_flag   [3];
    logic [7:0]  rec_addr1       [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_rec();
        for (int i = 0; i < 3; i++) begin
            rec_re[i] = 0;
            rec_pop[i] = 0;
            rec_done[i] = 0;
            rec_done_cyc[i] = -1;
            rec_first_valid[i] = -1;
            rec_first_word[i] = '0;
            rec_last_word[i] = '0;
            rec_last_flag[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) rec_addr1[i] = '0;
    endtask

    task automatic check_inst(input int i, input logic re, input logic [7:0] addr,
                              input logic busy, input logic done, input logic valid,
                              input logic [31:0] data, input logic last);
        string p;
        logic  pop;
        logic  fin;
        p   = $sformatf("u%0d", i);
        pop = valid & ready;

        chk({p, "_busy"}, busy, m_busy[i]);
        chk({p, "_done"}, done, m_done[i]);
        if (re) begin
            chk({p, "_read_allowed"}, (m_busy[i] != 0) && (m_issued[i] < wc_a[i]), 1);
            chk({p, "_mem_addr"}, addr, (base_a[i] + m_issued[i]) % 256);
        end
        if (m_hold[i] != 0) chk({p, "_valid_held"}, valid, 1);
        if (valid) begin
            chk({p, "_valid_in_transfer"}, (m_busy[i] != 0) && (m_popped[i] < wc_a[i]), 1);
            chk({p, "_out_data"}, data, ram[(base_a[i] + m_popped[i]) % 256]);
            chk({p, "_out_last"}, last, m_popped[i] == wc_a[i] - 1);
        end
        chk({p, "_outstanding"},
            (m_issued[i] + int'(re)) - (m_popped[i] + int'(pop)) <= 2, 1);

        if (re) begin
            if (i == 1 && rec_re[1] < 4) rec_addr1[rec_re[1]] = addr;
            rec_re[i]++;
        end
        if (valid && rec_first_valid[i] < 0) rec_first_valid[i] = cyc;
        if (pop) begin
            if (rec_pop[i] == 0) rec_first_word[i] = data;
            rec_last_word[i] = data;
            rec_last_flag[i] = last;
            rec_pop[i]++;
        end
        if (done) begin
            rec_done[i]++;
            rec_done_cyc[i] = cyc;
        end

        if (!rst_n) begin
            m_busy[i] = 0;
            m_done[i] = 0;
            m_issued[i] = 0;
            m_popped[i] = 0;
            m_hold[i] = 0;
        end else begin
            fin = pop && (m_popped[i] == wc_a[i] - 1);
            m_issued[i] += int'(re);
            m_popped[i] += int'(pop);
            if (m_busy[i] != 0) begin
                if (fin) begin
                    m_busy[i] = 0;
                    m_done[i] = 1;
                end
            end else if (m_done[i] != 0) begin
                m_done[i] = 0;
            end else if (start) begin
                m_busy[i] = 1;
                m_issued[i] = 0;
                m_popped[i] = 0;
            end
            m_hold[i] = int'(valid & ~ready);
        end
    endtask

    always @(negedge clk) begin
        check_inst(0, ia.mem_re, ia.mem_addr, ia.busy, ia.done, ia.out_valid, ia.out_data, ia.out_last);
        check_inst(1, ib.mem_re, ib.mem_addr, ib.busy, ib.done, ib.out_valid, ib.out_data, ib.out_last);
        check_inst(2, ic.mem_re, ic.mem_addr, ic.busy, ic.done, ic.out_valid, ic.out_data, ic.out_last);
    end

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (rec_done[0] < target && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, rec_done[0] >= target, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE0000 | i;
        ram[0] = 32'h6A09E667; ram[1] = 32'hBB67AE85; ram[2] = 32'h3C6EF372; ram[3] = 32'hA54FF53A;
        ram[4] = 32'h510E527F; ram[5] = 32'h9B05688C; ram[6] = 32'h1F83D9AB; ram[7] = 32'h5BE0CD19;
        clear_rec();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {ia.busy, ia.done, ia.mem_re, ia.out_valid, ia.out_last}, 0);
        chk("reset_addr", ia.mem_addr, 0);
        chk("reset_data", ia.out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // 1 / 3 / 6: full-rate transfer on all three readers
        clear_rec();
        ready = 1'b1;
        pulse_start(s);
        wait_done(1, "t1_done_seen");
        chk("t1_first_valid_latency", rec_first_valid[0] - s, 3);
        chk("t1_done_cycle", rec_done_cyc[0] - s, 11);
        chk("t1_words", rec_pop[0], 8);
        chk("t1_reads", rec_re[0], 8);
        chk("t1_first_word", rec_first_word[0], 32'h6A09E667);
        chk("t1_last_word", rec_last_word[0], 32'h5BE0CD19);
        chk("t1_last_flag", rec_last_flag[0], 1);
        chk("t3_addr0", rec_addr1[0], 8'hFE);
        chk("t3_addr1", rec_addr1[1], 8'hFF);
        chk("t3_addr2", rec_addr1[2], 8'h00);
        chk("t3_addr3", rec_addr1[3], 8'h01);
        chk("t3_first_word", rec_first_word[1], 32'hC0DE00FE);
        chk("t3_last_word", rec_last_word[1], 32'hBB67AE85);
        chk("t3_words", rec_pop[1], 4);
        chk("t6_reads", rec_re[2], 1);
        chk("t6_words", rec_pop[2], 1);
        chk("t6_last_flag", rec_last_flag[2], 1);
        chk("t6_word", rec_first_word[2], 32'h6A09E667);
        chk("t6_done_cycle", rec_done_cyc[2] - s, 4);
        repeat (3) @(posedge clk); #1;

        // 2: consumer toggling and a 5-cycle stall
        clear_rec();
        for (int j = 0; j < 300 && rec_done[0] < 1; j++) begin
            ready = (j >= 6 && j < 11) ? 1'b0 : ((j % 2) == 0);
            start = (j == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        ready = 1'b1;
        chk("t2_done_seen", rec_done[0] >= 1, 1);
        chk("t2_words", rec_pop[0], 8);
        chk("t2_reads", rec_re[0], 8);
        chk("t2_last_word", rec_last_word[0], 32'h5BE0CD19);
        chk("t2_last_flag", rec_last_flag[0], 1);
        repeat (3) @(posedge clk); #1;

        // 4: reset after three words, then a fresh transfer
        clear_rec();
        pulse_start(s);
        for (int j = 0; j < 50 && rec_pop[0] < 3; j++) begin
            @(posedge clk); #1;
        end
        chk("t4_three_popped", rec_pop[0] >= 3, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_rst_ctl", {ia.busy, ia.done, ia.mem_re, ia.out_valid, ia.out_last}, 0);
        chk("t4_rst_addr", ia.mem_addr, 0);
        chk("t4_rst_data", ia.out_data, 0);
        repeat (4) @(posedge clk); #1;
        chk("t4_no_done", rec_done[0], 0);
        clear_rec();
        pulse_start(s);
        wait_done(1, "t4_restart_done_seen");
        chk("t4_restart_first_word", rec_first_word[0], 32'h6A09E667);
        chk("t4_restart_words", rec_pop[0], 8);
        chk("t4_restart_done_cycle", rec_done_cyc[0] - s, 11);
        repeat (3) @(posedge clk); #1;

        // 5: start held for 20 cycles
        clear_rec();
        start = 1'b1;
        s = cyc;
        repeat (20) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2, "t5_second_done_seen");
        repeat (6) @(posedge clk); #1;
        chk("t5_transfers", rec_done[0], 2);
        chk("t5_reads", rec_re[0], 16);
        chk("t5_words", rec_pop[0], 16);
        chk("t5_second_done_cycle", rec_done_cyc[0] - s, 23);
        chk("t5_u2_transfers", rec_done[2], 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
